// File: rtl/mips_trace_buffer.sv
// ---------------------------------------------------------------------------
// mips_trace_buffer
//
// Captures the MIPS core's register-writeback stream into a circular buffer
// so a debug host or checker can read it out after (or during) a run. An
// optional PC-match trigger delays the start of capture until a chosen
// instruction commits.
//
// Configuration macro:
//   TRACE_WRAP_EN  defined   -> a push into a full buffer (with no pop in the
//                               same cycle) overwrites the oldest entry.
//                  undefined -> such a push is dropped; contents are kept.
//                  In both builds the event sets overflow and bumps drop_cnt.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 4)
//   AW     pointer width, log2(DEPTH)
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous active-low reset
//   cap_en          capture master enable
//   trig_en         1: wait for pc_in == trig_pc before capturing
//   trig_pc         trigger PC
//   clr             synchronous clear of buffer, counters, flags and FSM
//   reg_write       core writes the register file this cycle
//   pc_in           PC of the committing instruction
//   inst            committing instruction word
//   write_reg       destination register (r0 writes are never captured)
//   write_data_reg  writeback data
//   rd_valid        head entry available (count != 0)
//   rd_ready        consumer accepts the head entry
//   rd_pc/rd_inst/rd_reg/rd_data  head entry fields (show-ahead, zero when empty)
//   count           occupied entries, 0..DEPTH
//   overflow        sticky: a capture hit a full buffer
//   drop_cnt        dropped/overwritten captures, saturating at 16'hFFFF
//   state           FSM state: IDLE=0, ARMED=1, RUN=2
//
// Read handshake: an entry leaves the buffer at a rising edge where
// rd_valid && rd_ready; rd_* stay stable while rd_valid && !rd_ready.
// ---------------------------------------------------------------------------
module mips_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cap_en,
    input  logic        trig_en,
    input  logic [31:0] trig_pc,
    input  logic        clr,
    input  logic        reg_write,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst,
    input  logic [4:0]  write_reg,
    input  logic [31:0] write_data_reg,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_pc,
    output logic [31:0] rd_inst,
    output logic [31:0] rd_data,
    output logic [4:0]  rd_reg,
    output logic [AW:0] count,
    output logic        overflow,
    output logic [15:0] drop_cnt,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [15:0]   DROP_MAX = 16'hFFFF;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          overflow_q;
    logic          overflow_d;
    logic [15:0]   drop_cnt_q;
    logic [15:0]   drop_cnt_d;

    // Entry storage; deliberately not reset.
    logic [31:0] mem_pc   [DEPTH];
    logic [31:0] mem_inst [DEPTH];
    logic [4:0]  mem_reg  [DEPTH];
    logic [31:0] mem_data [DEPTH];

    // -----------------------------------------------------------------------
    // Event decode
    // -----------------------------------------------------------------------
    logic pc_match;
    logic trig_hit;
    logic capture_win;
    logic push;
    logic pop;
    logic full;
    logic mem_we;

    assign pc_match = (pc_in == trig_pc);

    // The ARMED->RUN match cycle is itself a capture window, so the
    // triggering instruction is the first entry in the buffer.
    assign trig_hit    = (state_q == ST_ARMED) && cap_en && pc_match;
    assign capture_win = (state_q == ST_RUN) || trig_hit;

    // Writes to r0 are architecturally void and are filtered out.
    assign push = capture_win && reg_write && (write_reg != 5'd0);

    assign rd_valid = (count_q != '0);
    assign pop      = rd_valid && rd_ready;
    assign full     = (count_q == CNT_FULL);

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (clr || !cap_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = trig_en ? ST_ARMED : ST_RUN;
                ST_ARMED: if (pc_match) state_d = ST_RUN;
                ST_RUN:   state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Pointer, occupancy and flag next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        mem_we     = 1'b0;

        if (clr) begin
            // Clear wins over any push/pop in the same cycle.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (push && full && !pop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != DROP_MAX) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
`ifdef TRACE_WRAP_EN
            // Overwrite the oldest entry: both pointers move, count stays full.
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
`endif
        end else begin
            // When full with a simultaneous pop, wr_ptr == rd_ptr: the slot
            // being read out this edge is the one being refilled.
            if (push) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Entry storage
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_pc[wr_ptr_q]   <= pc_in;
            mem_inst[wr_ptr_q] <= inst;
            mem_reg[wr_ptr_q]  <= write_reg;
            mem_data[wr_ptr_q] <= write_data_reg;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Head fields are forced to zero while empty so uninitialised storage
    // never leaks onto the read port.
    assign rd_pc    = rd_valid ? mem_pc[rd_ptr_q]   : 32'd0;
    assign rd_inst  = rd_valid ? mem_inst[rd_ptr_q] : 32'd0;
    assign rd_reg   = rd_valid ? mem_reg[rd_ptr_q]  : 5'd0;
    assign rd_data  = rd_valid ? mem_data[rd_ptr_q] : 32'd0;

    assign count    = count_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
    assign state    = state_q;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_mips_trace_buffer
//
// Self-checking bench for mips_trace_buffer. Inputs change 1 ns after each
// rising edge. A reference model runs on every rising edge and keeps the
// expected buffer contents as a queue of entries; a monitor on the falling
// edge compares the DUT's flags against the model and, on every read
// handshake, pops the expected head and compares it with the rd_* fields.
// ---------------------------------------------------------------------------
module tb_mips_trace_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int EW    = 101;   // {pc, inst, reg, data}

    logic        clk;
    logic        rst;
    logic        cap_en;
    logic        trig_en;
    logic [31:0] trig_pc;
    logic        clr;
    logic        reg_write;
    logic [31:0] pc_in;
    logic [31:0] inst;
    logic [4:0]  write_reg;
    logic [31:0] write_data_reg;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_pc;
    logic [31:0] rd_inst;
    logic [31:0] rd_data;
    logic [4:0]  rd_reg;
    logic [AW:0] count;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [1:0]  state;

    mips_trace_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .cap_en         (cap_en),
        .trig_en        (trig_en),
        .trig_pc        (trig_pc),
        .clr            (clr),
        .reg_write      (reg_write),
        .pc_in          (pc_in),
        .inst           (inst),
        .write_reg      (write_reg),
        .write_data_reg (write_data_reg),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_pc          (rd_pc),
        .rd_inst        (rd_inst),
        .rd_data        (rd_data),
        .rd_reg         (rd_reg),
        .count          (count),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt),
        .state          (state)
    );

    // -----------------------------------------------------------------------
    // Clock
    // -----------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Scoreboard state
    // -----------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    logic [EW-1:0] exp_q[$];      // expected buffer contents, oldest first
    int            m_state = 0;   // 0 idle, 1 armed, 2 run
    bit            m_ovf   = 1'b0;
    int            m_drop  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_state = 0;
        m_ovf   = 1'b0;
        m_drop  = 0;
    endtask

    // One rising edge of the capture rules, evaluated on the inputs of the
    // cycle that just ended. Reads of this cycle were already removed from
    // exp_q by the monitor, so "full" here means full after any pop.
    task automatic model_step();
        bit hit;
        bit do_push;
        if (clr) begin
            model_clear();
            return;
        end
        hit     = (m_state == 1) && cap_en && (pc_in == trig_pc);
        do_push = (m_state == 2 || hit) && reg_write && (write_reg != 5'd0);
        if (do_push) begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back({pc_in, inst, write_reg, write_data_reg});
            end else begin
                m_ovf = 1'b1;
                if (m_drop < 65535) m_drop++;
`ifdef TRACE_WRAP_EN
                void'(exp_q.pop_front());
                exp_q.push_back({pc_in, inst, write_reg, write_data_reg});
`endif
            end
        end
        if (!cap_en)           m_state = 0;
        else if (m_state == 0) m_state = trig_en ? 1 : 2;
        else if (hit)          m_state = 2;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_clear();
            else      model_step();
        end
    end

    // -----------------------------------------------------------------------
    // Monitor
    // -----------------------------------------------------------------------
    initial begin
        logic [EW-1:0] head;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                check("rd_valid", rd_valid, exp_q.size() != 0);
                check("count", count, exp_q.size());
                check("state", state, m_state);
                check("overflow", overflow, m_ovf);
                check("drop_cnt", drop_cnt, m_drop);
                if (exp_q.size() != 0 && rd_ready) begin
                    head = exp_q.pop_front();
                    check("rd_entry", {rd_pc, rd_inst, rd_reg, rd_data}, head);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Driver helpers
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic rw, input logic [31:0] pc,
                          input logic [4:0] r, input logic [31:0] d);
        reg_write      = rw;
        pc_in          = pc;
        inst           = pc ^ 32'h2000_0000;
        write_reg      = r;
        write_data_reg = d;
    endtask

    task automatic quiet();
        set_wb(1'b0, 32'd0, 5'd0, 32'd0);
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        rst      = 1'b0;
        cap_en   = 1'b0;
        trig_en  = 1'b0;
        trig_pc  = 32'd0;
        clr      = 1'b0;
        rd_ready = 1'b0;
        quiet();

        // Reset
        repeat (3) tick();
        rst = 1'b1;
        check("reset_count", count, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_state", state, 0);
        check("reset_overflow", overflow, 0);
        check("reset_drop", drop_cnt, 0);
        check("reset_rd_fields", {rd_pc, rd_inst, rd_reg, rd_data}, 0);
        tick();

        // Immediate capture
        cap_en = 1'b1;
        tick();                                // IDLE -> RUN
        check("imm_state_run", state, 2);
        set_wb(1'b1, 32'h100, 5'd8,  32'h11); tick();
        set_wb(1'b1, 32'h104, 5'd9,  32'h22); tick();
        set_wb(1'b1, 32'h108, 5'd10, 32'h33); tick();
        quiet();
        check("imm_count", count, 3);
        check("imm_head_reg", rd_reg, 8);
        check("imm_head_data", rd_data, 32'h11);
        rd_ready = 1'b1;
        repeat (3) tick();
        rd_ready = 1'b0;
        check("imm_drained", rd_valid, 0);

        // Filtering: r0 writes and non-writes are ignored
        set_wb(1'b1, 32'h200, 5'd0, 32'hDEAD);
        repeat (3) tick();
        set_wb(1'b0, 32'h204, 5'd5, 32'hBEEF);
        repeat (3) tick();
        quiet();
        check("filter_count", count, 0);

        // Trigger
        cap_en = 1'b0;
        tick();
        cap_en  = 1'b1;
        trig_en = 1'b1;
        trig_pc = 32'h10;
        tick();                                // IDLE -> ARMED
        check("trig_armed", state, 1);
        for (int p = 0; p <= 32'h18; p += 4) begin
            set_wb(1'b1, 32'(p), 5'd1, 32'h1000 + 32'(p));
            if (p == 32'h10) check("trig_before_edge", state, 1);
            tick();
            if (p == 32'h10) check("trig_after_edge", state, 2);
        end
        quiet();
        check("trig_count", count, 3);
        check("trig_first_pc", rd_pc, 32'h10);
        clr = 1'b1; tick(); clr = 1'b0;
        trig_en = 1'b0;

        // Overflow: 20 pushes, no pops
        tick();                                // IDLE -> RUN
        for (int i = 1; i <= 20; i++) begin
            set_wb(1'b1, 32'h300 + 32'(4 * i), 5'(i), 32'hA0 + 32'(i));
            tick();
        end
        quiet();
        check("ovf_count", count, 16);
        check("ovf_drop", drop_cnt, 4);
        check("ovf_flag", overflow, 1);
`ifdef TRACE_WRAP_EN
        check("ovf_head", rd_data, 32'hA5);
`else
        check("ovf_head", rd_data, 32'hA1);
`endif
        clr = 1'b1; tick(); clr = 1'b0;

        // Full buffer with simultaneous push and pop
        tick();                                // IDLE -> RUN
        for (int i = 0; i < 16; i++) begin
            set_wb(1'b1, 32'h400 + 32'(4 * i), 5'd3, 32'hB00 + 32'(i));
            tick();
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_wb(1'b1, 32'h500 + 32'(4 * i), 5'd4, 32'hC00 + 32'(i));
            tick();
        end
        rd_ready = 1'b0;
        quiet();
        check("full_pp_count", count, 16);
        check("full_pp_overflow", overflow, 0);
        check("full_pp_drop", drop_cnt, 0);
        clr = 1'b1; tick(); clr = 1'b0;

        // Randomised traffic
        trig_pc = 32'h20;
        for (int i = 0; i < 1200; i++) begin
            int rdy_pct;
            cap_en  = ($urandom_range(0, 99) >= 3);
            trig_en = ($urandom_range(0, 3) == 0);
            clr     = ($urandom_range(0, 249) == 0);
            set_wb(cap_en && ($urandom_range(0, 3) != 0),
                   32'($urandom_range(0, 15)) << 2,
                   ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                   $urandom);
            rdy_pct  = ((i / 150) % 2 == 0) ? 20 : 85;
            rd_ready = ($urandom_range(0, 99) < rdy_pct);
            tick();
        end
        clr = 1'b0;
        rd_ready = 1'b0;
        cap_en = 1'b1;
        trig_en = 1'b0;
        quiet();
        clr = 1'b1; tick(); clr = 1'b0;

        // Asynchronous reset mid-run
        tick();                                // IDLE -> RUN
        for (int i = 0; i < 5; i++) begin
            set_wb(1'b1, 32'h600 + 32'(4 * i), 5'd7, 32'hD00 + 32'(i));
            tick();
        end
        quiet();
        check("pre_rst_count", count, 5);
        check("pre_rst_state", state, 2);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_valid", rd_valid, 0);
        check("async_rst_state", state, 0);
        cap_en = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Clear together with a push
        cap_en = 1'b1;
        tick();                                // IDLE -> RUN
        set_wb(1'b1, 32'h700, 5'd2, 32'hE0); tick();
        set_wb(1'b1, 32'h704, 5'd2, 32'hE1); tick();
        check("pre_clr_count", count, 2);
        clr = 1'b1;
        set_wb(1'b1, 32'h708, 5'd2, 32'hE2);
        tick();
        clr = 1'b0;
        quiet();
        check("clr_push_count", count, 0);
        check("clr_push_state", state, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_trace_buffer.md
# mips_trace_buffer

Captures the MIPS core's register-writeback stream into an on-chip circular buffer for post-run inspection. It sits beside `MipsCPU` and taps the same commit signals the top-level bench watches: `pc_in`, `inst`, `write_reg` and `write_data_reg`. It drains the captured entries through a valid/ready read port to a debug host or checker. A PC-match trigger starts capture at a chosen instruction.

## Interface
- `DEPTH`, 16, number of entries; power of two, at least 4.
- `AW`, 4, pointer width; must equal log2(`DEPTH`).
- `clk`  in  1  system clock; everything is updated on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cap_en`  in  1  capture master enable.
- `trig_en`  in  1  when 1, capture waits for a PC match; when 0, capture starts immediately.
- `trig_pc`  in  32  trigger PC.
- `clr`  in  1  synchronous clear of buffer, counters and flags.
- `reg_write`  in  1  the core writes the register file this cycle.
- `pc_in`  in  32  PC of the committing instruction.
- `inst`  in  32  committing instruction word.
- `write_reg`  in  5  destination register.
- `write_data_reg`  in  32  writeback data.
- `rd_valid`  out  1  head entry is available.
- `rd_ready`  in  1  consumer accepts the head entry.
- `rd_pc`, `rd_inst`, `rd_data`  out  32 each  head entry fields.
- `rd_reg`  out  5  head entry destination register.
- `count`  out  AW+1  number of occupied entries.
- `overflow`  out  1  sticky; a capture hit a full buffer.
- `drop_cnt`  out  16  number of dropped captures; saturates at 16'hFFFF.
- `state`  out  2  FSM state: IDLE=0, ARMED=1, RUN=2.

## Operation
- **FSM, IDLE state**
  - `cap_en` = 1 and `trig_en` = 0 → RUN.
  - `cap_en` = 1 and `trig_en` = 1 → ARMED.
- **FSM, ARMED state**
  - `pc_in` == `trig_pc` → RUN. The matching cycle is itself captured if it is a qualifying event.
- **FSM, any state**
  - `cap_en` = 0 → IDLE. This applies in ARMED and RUN.
  - `clr` → IDLE.
- **Push event**
  - Definition: (state == RUN, or the ARMED→RUN match cycle) AND `reg_write` AND `write_reg` != 0.
  - Stores {`pc_in`, `inst`, `write_reg`, `write_data_reg`} at the write pointer.
- **Pop event**
  - Definition: `rd_valid` AND `rd_ready`. Advances the read pointer.
- **Read port**
  - `rd_*` present the entry at the read pointer (show-ahead).
  - `rd_valid` = (`count` != 0).
  - `rd_*` hold stable while `rd_valid` is high and `rd_ready` is low.
- **Pointer arithmetic**
  - Pointers are AW bits and wrap modulo `DEPTH`.
  - `count` changes by +1 on push only, -1 on pop only, and is unchanged on simultaneous push and pop.
- **Push when full without a pop**
  - Behaviour depends on the configuration macro (see Configuration).
  - Always sets `overflow`.
- **Push when full with a simultaneous pop**
  - Accepted normally.
  - No overflow, no drop.
- **Push when empty with a simultaneous pop**
  - Impossible, because `rd_valid` = 0. It is a plain push.
- **`clr`**
  - Zeroes both pointers, `count`, `overflow` and `drop_cnt`, and returns the FSM to IDLE.
  - Has priority over push and pop in the same cycle. The event in that cycle is discarded.
- **Reset**
  - Has the same effect as `clr`, applied asynchronously.
  - Outputs: `rd_valid` = 0, `count` = 0, `overflow` = 0, `drop_cnt` = 0, `state` = IDLE.
  - `rd_pc`, `rd_inst`, `rd_data` = 0 and `rd_reg` = 0 while empty after reset. Storage is not cleared.

## Timing
- **Capture latency:** a push at edge N makes the entry visible, with `rd_valid` = 1 and `count` incremented, after edge N. That is one cycle.
- **Pop:** takes effect at the edge where `rd_valid` & `rd_ready` = 1. The next entry appears after that same edge.
- **Throughput:** one push and one pop per cycle, sustained.
- **FSM:** transitions take effect at the clock edge. `state` is registered.
- **Reset release:** `rst` is released synchronously to `clk` by the system. The block assumes no event in the release cycle.

## Configuration
- **Macro:** `TRACE_WRAP_EN`.
- **Defined:** a push to a full buffer without a pop overwrites the oldest entry.
  - Both pointers advance and `count` stays at `DEPTH`.
  - `overflow` is set; `drop_cnt` counts overwritten entries.
- **Undefined:** a push to a full buffer without a pop is dropped.
  - Buffer contents and pointers are unchanged.
  - `overflow` is set; `drop_cnt` increments, saturating.

## Test plan
- **Reset and immediate capture:** reset, then `cap_en` = 1, `trig_en` = 0, and 3 writebacks (r8=0x11, r9=0x22, r10=0x33) with `rd_ready` = 0 → `count` = 3 and `rd_reg` = 8, `rd_data` = 0x11. Pulse `rd_ready` for 3 cycles → entries r8, r9, r10 in order, then `rd_valid` = 0.
- **Filtering:** `reg_write` = 1 with `write_reg` = 0, plus `reg_write` = 0 cycles → `count` stays 0.
- **Trigger:** `trig_en` = 1, `trig_pc` = 0x0000_0010, PCs 0x0, 0x4, ..., 0x18 each writing r1 → first captured `rd_pc` = 0x10 and `count` = 3. `state` goes 1→2 at the 0x10 edge.
- **Overflow:** `DEPTH` = 16, 20 pushes, no pops.
  - With `TRACE_WRAP_EN`: `count` = 16, `drop_cnt` = 4, `overflow` = 1, and the head is the 5th push.
  - Without it: `count` = 16, `drop_cnt` = 4, and the head is the 1st push.
- **Full with simultaneous push and pop:** full buffer, push and pop in the same cycle for 10 cycles → `count` = 16, `overflow` = 0, `drop_cnt` = 0.
- **Reset and clear mid-run:** in RUN with `count` = 5, assert `rst` low mid-cycle → `count` = 0, `rd_valid` = 0 and `state` = 0 immediately, without waiting for an edge. Separately, `clr` together with a push → `count` = 0 next cycle.
